// File: rtl/mux_nto1_tdm.sv
// rtl/mux_nto1_tdm.sv - N:1 time-division multiplexer with per-lane valid
// Double-buffered frame capture, one lane per clk_4f cycle, fixed-slot or compact emission.
module mux_nto1_tdm #(
  parameter int WIDTH   = 8,
  parameter int N       = 4,
  parameter int COMPACT = 0
) (
  input  logic                 clk_4f,
  input  logic                 reset_L,
  input  logic                 sync_in,
  input  logic [N-1:0]         valid_in,
  input  logic [N*WIDTH-1:0]   data_in,
  output logic                 valid_out,
  output logic [WIDTH-1:0]     data_out,
  output logic [$clog2(N)-1:0] lane_out,
  output logic                 frame_start_out
);

  localparam int CW = $clog2(N);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N-1:0]       cap_valid_q, hold_valid_q;
  logic [N*WIDTH-1:0] cap_data_q, hold_data_q;
  logic [N-1:0]       pend_q, pend_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [CW-1:0]      lane_q, lane_d;
  logic               fs_q, fs_d;

  logic               capture;
  logic [N-1:0]       src_valid;
  logic [N*WIDTH-1:0] src_data;
  logic [CW-1:0]      slot;
  logic [N-1:0]       mask;
  logic               found;
  logic [CW-1:0]      idx;
  logic [WIDTH-1:0]   sel_data;

  always_comb begin
    capture   = sync_in || (cnt_q == '0);
    // Slot 0 is taken from the capture buffer as it moves into hold on this edge.
    src_valid = capture ? cap_valid_q : hold_valid_q;
    src_data  = capture ? cap_data_q  : hold_data_q;
    slot      = capture ? '0 : cnt_q;
    mask      = capture ? src_valid : pend_q;

    if (capture)
      cnt_d = CW'(1);
    else if (cnt_q == CW'(N - 1))
      cnt_d = '0;
    else
      cnt_d = cnt_q + CW'(1);

    found = 1'b0;
    idx   = '0;
    if (COMPACT != 0) begin
      // Downward scan so the lowest pending lane wins.
      for (int j = N - 1; j >= 0; j--) begin
        if (mask[j]) begin
          found = 1'b1;
          idx   = CW'(j);
        end
      end
    end else begin
      found = src_valid[slot];
      idx   = slot;
    end

    pend_d = '0;
    for (int j = 0; j < N; j++)
      pend_d[j] = mask[j] && !(found && (idx == CW'(j)));

    sel_data = '0;
    for (int j = 0; j < N; j++)
      if (idx == CW'(j))
        sel_data = src_data[j*WIDTH +: WIDTH];

    valid_d = found;
    data_d  = found ? sel_data : '0;
    lane_d  = found ? idx : '0;
    fs_d    = capture;
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      cnt_q        <= '0;
      cap_valid_q  <= '0;
      cap_data_q   <= '0;
      hold_valid_q <= '0;
      hold_data_q  <= '0;
      pend_q       <= '0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      lane_q       <= '0;
      fs_q         <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      lane_q  <= lane_d;
      fs_q    <= fs_d;
      if (capture) begin
        cap_valid_q  <= valid_in;
        cap_data_q   <= data_in;
        hold_valid_q <= cap_valid_q;
        hold_data_q  <= cap_data_q;
      end
    end
  end

  assign valid_out       = valid_q;
  assign data_out        = data_q;
  assign lane_out        = lane_q;
  assign frame_start_out = fs_q;

endmodule

// File: tb/tb_mux_nto1_tdm.sv
// tb/tb_mux_nto1_tdm.sv - randomized bench for mux_nto1_tdm against a frame/slot-list model
// Four instances: N=4 W=8 fixed, N=4 W=8 compact, N=2 W=16 fixed, N=8 W=16 fixed.
module tb_mux_nto1_tdm;

  logic clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  logic reset_L;
  logic sync_in;

  logic [3:0]   v0, v1;
  logic [31:0]  d0, d1;
  logic [1:0]   v2;
  logic [31:0]  d2;
  logic [7:0]   v3;
  logic [127:0] d3;

  logic        ov0, ov1, ov2, ov3;
  logic [7:0]  od0, od1;
  logic [15:0] od2, od3;
  logic [1:0]  ol0, ol1;
  logic        ol2;
  logic [2:0]  ol3;
  logic        of0, of1, of2, of3;

  logic [7:0]  in_v [4];
  logic [15:0] in_d [4][8];

  logic        ov [4];
  logic [15:0] od [4];
  logic [2:0]  ol [4];
  logic        ofs [4];

  always_comb begin
    v0 = in_v[0][3:0];
    v1 = in_v[1][3:0];
    v2 = in_v[2][1:0];
    v3 = in_v[3];
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    for (int j = 0; j < 4; j++) begin
      d0[j*8 +: 8] = in_d[0][j][7:0];
      d1[j*8 +: 8] = in_d[1][j][7:0];
    end
    for (int j = 0; j < 2; j++) d2[j*16 +: 16] = in_d[2][j];
    for (int j = 0; j < 8; j++) d3[j*16 +: 16] = in_d[3][j];
  end

  always_comb begin
    ov[0] = ov0; od[0] = {8'h00, od0}; ol[0] = {1'b0, ol0};  ofs[0] = of0;
    ov[1] = ov1; od[1] = {8'h00, od1}; ol[1] = {1'b0, ol1};  ofs[1] = of1;
    ov[2] = ov2; od[2] = od2;          ol[2] = {2'b00, ol2}; ofs[2] = of2;
    ov[3] = ov3; od[3] = od3;          ol[3] = ol3;          ofs[3] = of3;
  end

  mux_nto1_tdm #(.WIDTH(8), .N(4), .COMPACT(0)) u_fix4 (
    .clk_4f(clk_4f), .reset_L(reset_L), .sync_in(sync_in),
    .valid_in(v0), .data_in(d0),
    .valid_out(ov0), .data_out(od0), .lane_out(ol0), .frame_start_out(of0));

  mux_nto1_tdm #(.WIDTH(8), .N(4), .COMPACT(1)) u_cmp4 (
    .clk_4f(clk_4f), .reset_L(reset_L), .sync_in(sync_in),
    .valid_in(v1), .data_in(d1),
    .valid_out(ov1), .data_out(od1), .lane_out(ol1), .frame_start_out(of1));

  mux_nto1_tdm #(.WIDTH(16), .N(2), .COMPACT(0)) u_fix2 (
    .clk_4f(clk_4f), .reset_L(reset_L), .sync_in(sync_in),
    .valid_in(v2), .data_in(d2),
    .valid_out(ov2), .data_out(od2), .lane_out(ol2), .frame_start_out(of2));

  mux_nto1_tdm #(.WIDTH(16), .N(8), .COMPACT(0)) u_fix8 (
    .clk_4f(clk_4f), .reset_L(reset_L), .sync_in(sync_in),
    .valid_in(v3), .data_in(d3),
    .valid_out(ov3), .data_out(od3), .lane_out(ol3), .frame_start_out(of3));

  // Model: the last captured frame, plus the slot list of the frame being emitted.
  logic [7:0]  cap_v [4];
  logic [15:0] cap_d [4][8];
  logic        sv [4][8];
  logic [15:0] sd [4][8];
  logic [2:0]  sl [4][8];
  int          pos [4];

  logic        ev [4];
  logic [15:0] ed [4];
  logic [2:0]  el [4];
  logic        ef [4];

  int n_checks = 0;
  int n_errors = 0;

  function automatic int nk(input int k);
    return (k == 2) ? 2 : (k == 3) ? 8 : 4;
  endfunction

  function automatic bit is_compact(input int k);
    return k == 1;
  endfunction

  function automatic logic [15:0] dmask(input int k);
    return (k >= 2) ? 16'hFFFF : 16'h00FF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      cap_v[k] = '0;
      for (int j = 0; j < 8; j++) cap_d[k][j] = '0;
      pos[k] = nk(k);
    end
  endtask

  task automatic expect_zero();
    for (int k = 0; k < 4; k++) begin
      ev[k] = 1'b0; ed[k] = '0; el[k] = '0; ef[k] = 1'b0;
    end
  endtask

  // A new frame starts when the previous slot list is used up or sync is high.
  task automatic model_edge();
    int n, c;
    for (int k = 0; k < 4; k++) begin
      n = nk(k);
      if (sync_in || pos[k] >= n) begin
        for (int s = 0; s < 8; s++) begin
          sv[k][s] = 1'b0; sd[k][s] = '0; sl[k][s] = '0;
        end
        c = 0;
        for (int j = 0; j < n; j++) begin
          if (cap_v[k][j]) begin
            c = is_compact(k) ? c : j;
            sv[k][c] = 1'b1;
            sd[k][c] = cap_d[k][j];
            sl[k][c] = 3'(j);
            c++;
          end
        end
        pos[k] = 0;
        cap_v[k] = in_v[k];
        for (int j = 0; j < 8; j++) cap_d[k][j] = in_d[k][j];
      end
      ev[k] = sv[k][pos[k]];
      ed[k] = sd[k][pos[k]];
      el[k] = sl[k][pos[k]];
      ef[k] = (pos[k] == 0);
      pos[k]++;
    end
  endtask

  task automatic compare_all(input string ph);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s dut%0d valid_out", ph, k), 32'(ov[k]), 32'(ev[k]));
      check($sformatf("%s dut%0d data_out", ph, k), 32'(od[k]), 32'(ed[k]));
      check($sformatf("%s dut%0d lane_out", ph, k), 32'(ol[k]), 32'(el[k]));
      check($sformatf("%s dut%0d frame_start_out", ph, k), 32'(ofs[k]), 32'(ef[k]));
    end
  endtask

  task automatic set_random_inputs();
    int n;
    for (int k = 0; k < 4; k++) begin
      n = nk(k);
      in_v[k] = 8'($urandom) & 8'((1 << n) - 1);
      for (int j = 0; j < 8; j++)
        in_d[k][j] = (j < n) ? (16'($urandom) & dmask(k)) : 16'h0000;
    end
  endtask

  task automatic set_abcd(input logic [3:0] v);
    for (int k = 0; k < 2; k++) begin
      in_v[k] = {4'h0, v};
      in_d[k][0] = 16'h00AA; in_d[k][1] = 16'h00BB;
      in_d[k][2] = 16'h00CC; in_d[k][3] = 16'h00DD;
    end
  endtask

  task automatic step(input logic s, input string ph);
    sync_in = s;
    model_edge();
    @(posedge clk_4f);
    #1;
    compare_all(ph);
  endtask

  initial begin
    reset_L = 1'b0;
    sync_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_v[k] = '0;
      for (int j = 0; j < 8; j++) in_d[k][j] = '0;
    end
    model_reset();
    repeat (2) @(posedge clk_4f);
    #1;
    expect_zero();
    compare_all("reset");
    reset_L = 1'b1;

    repeat (10) step(1'b0, "idle");

    set_abcd(4'b1111);
    repeat (12) step(1'b0, "full");
    set_abcd(4'b1010);
    repeat (12) step(1'b0, "holes");
    set_abcd(4'b0000);
    repeat (10) step(1'b0, "empty");

    set_abcd(4'b1111);
    step(1'b1, "sync_a");
    step(1'b0, "sync_b");
    set_abcd(4'b0110);
    step(1'b1, "sync_cnt2");
    repeat (10) step(1'b0, "after_sync");
    repeat (4) step(1'b1, "sync_held");
    repeat (10) step(1'b0, "after_held");

    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        #2 reset_L = 1'b0;
        #1;
        expect_zero();
        compare_all("async_reset");
        @(posedge clk_4f);
        #1;
        compare_all("in_reset");
        reset_L = 1'b1;
        model_reset();
      end
      set_random_inputs();
      step(($urandom_range(0, 15) == 0), "random");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux_nto1_tdm.md
# mux_nto1_tdm

Parametrised N:1 time-division multiplexer with per-lane valid, the next-generation replacement for the fixed 2:1 byte mux stages in the striping/serialisation path. It samples a frame of N parallel lanes once every N fast-clock cycles, double-buffers it, and emits one lane per cycle on a single registered output. It runs in either fixed-slot mode (lane j always occupies slot j) or compact mode (only valid lanes are emitted, packed at the start of the frame). An internal slot counter replaces the external selector, and a sync input realigns frames.

## Interface
Parameters:
- WIDTH, 8, data bits per lane.
- N, 4, lane count; legal range 2..16; clk_4f runs at N times the lane rate.
- COMPACT, 0, 0 = fixed-slot mode, 1 = compact mode.

Ports:
- clk_4f  input  1  single clock, all logic on the rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- sync_in  input  1  synchronous frame-realign pulse.
- valid_in  input  N  per-lane valid; bit j belongs to lane j.
- data_in  input  N*WIDTH  lane j at bits [j*WIDTH +: WIDTH].
- valid_out  output  1  registered; output slot carries a lane.
- data_out  output  WIDTH  registered lane data; 0 whenever valid_out=0.
- lane_out  output  clog2(N)  index of the emitted lane; 0 whenever valid_out=0.
- frame_start_out  output  1  registered; high while the output holds slot 0 of a frame.

## Operation
- Slot counter cnt, width clog2(N), range 0..N-1. It increments every edge and wraps from N-1 to 0.
- Capture edge: any edge where cnt==0, or any edge where sync_in=1. At a capture edge:
  - valid_in/data_in are sampled into the capture buffer.
  - The previous capture buffer moves into the hold buffer.
  - cnt is set to 1.
- sync_in=1 while cnt!=0 truncates the current output frame. Slots not yet emitted are dropped and the new frame starts at slot 0.
- Emission (every edge, from the hold-side frame): slot s is emitted at the edge where the counter equals s. Slot 0 comes from the buffer transferred at that edge.
- Fixed mode (COMPACT=0):
  - valid_out=valid[s], data_out=data[s] (forced to 0 if the lane is invalid), lane_out=s (forced to 0 if invalid).
- Compact mode (COMPACT=1):
  - A pending mask is loaded from the frame valids at slot 0.
  - Each slot emits the lowest-index pending lane and clears its bit. lane_out carries that lane index.
  - Once pending is empty, the remaining slots output valid_out=0, data_out=0, lane_out=0.
  - Lane order within a frame is always ascending.
- frame_start_out=1 exactly on slot-0 emissions, in both modes, regardless of valid.
- Buffer contents need be stable only at the capture edge. Inputs between capture edges are ignored.

## Timing
- Reset (reset_L=0, asynchronous): cnt=0, both buffers cleared (valids 0, data 0), valid_out=0, data_out=0, lane_out=0, frame_start_out=0.
- Reset mid-frame discards all buffered lanes. No partial frame is emitted afterwards.
- The first edge after reset release is a capture edge (cnt=0).
- Latency: a frame captured at edge F appears on the outputs after edges F+N .. F+2N-1. Slot j is visible after edge F+N+j.
- This holds for free-running operation. After a sync_in capture at F, the frame captured at F is emitted starting at the next capture edge.
- The first N output slots after reset come from cleared buffers: valid_out=0, frame_start_out=1 on the first of them.
- Throughput: one lane per cycle, one frame per N cycles. No backpressure.
- sync_in asserted on an edge where cnt==0 is identical to a normal capture (no double capture).
- sync_in held high for consecutive edges: every such edge is a capture. Only slot 0 is ever emitted.

## Test plan
- Reset/idle: assert reset_L=0 mid-stream → all outputs 0 immediately (asynchronous). After release, N slots with valid_out=0, then frame_start_out pulses every N cycles.
- Fixed mode, N=4, WIDTH=8: capture valid=4'b1111, data={8'hDD,8'hCC,8'hBB,8'hAA} at edge F → after edges F+4..F+7, out = AA,BB,CC,DD, lane_out=0,1,2,3, frame_start only on AA.
- Fixed mode holes: valid=4'b1010 → slots AA(v=0,data 0), BB(v=1,lane 1), slot 2 v=0, DD(v=1,lane 3).
- Compact mode: valid=4'b1010, same data → slot 0 BB lane 1, slot 1 DD lane 3, slots 2-3 valid_out=0. valid=4'b0000 → all four slots invalid, frame_start still high on slot 0.
- sync_in pulse at cnt==2: the current frame is truncated after slot 1. The next edge's output is slot 0 of the previously captured frame with frame_start_out=1. The cadence then repeats every N cycles from the sync edge.
- Input glitching: change data_in/valid_in on non-capture edges → the output stream is unaffected. Repeat fixed-mode checks at N=2 and N=8, WIDTH=16.
